// File: rtl/demux3_stream.sv
// Registered 1-to-3 valid/ready stream demultiplexer with one-entry buffer per channel.
// Optional feature: define DEMUX3_ERRCNT_EN for a saturating dropped-beat counter on err_cnt.
module demux3_stream #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             c_valid,
    input  logic             c_ready,
    output logic [WIDTH-1:0] c_data,
    output logic             err,
    output logic [7:0]       err_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state  [3];
    logic [WIDTH-1:0] data_q [3];
    logic [2:0]       chan_ready;
    logic [2:0]       chan_hit;
    logic             accept;
    logic             illegal;

    assign chan_ready = {c_ready, b_ready, a_ready};

    always_comb begin
        chan_hit = '0;
        case (in_sel)
            2'b00:   chan_hit = 3'b001;
            2'b01:   chan_hit = 3'b010;
            2'b10:   chan_hit = 3'b100;
            default: chan_hit = 3'b000;
        endcase
    end

    // A full buffer can still take a beat when its consumer drains it this cycle.
    always_comb begin
        in_ready = 1'b1;
        case (in_sel)
            2'b00:   in_ready = (state[0] == EMPTY) | a_ready;
            2'b01:   in_ready = (state[1] == EMPTY) | b_ready;
            2'b10:   in_ready = (state[2] == EMPTY) | c_ready;
            default: in_ready = 1'b1;
        endcase
    end

    assign accept  = in_valid & in_ready;
    assign illegal = accept & (in_sel == 2'b11);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                state[i]  <= EMPTY;
                data_q[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (accept && chan_hit[i]) begin
                    state[i]  <= FULL;
                    data_q[i] <= in_data;
                end else if (chan_ready[i]) begin
                    state[i] <= EMPTY;
                end
            end
            err <= illegal;
        end
    end

    assign a_valid = (state[0] == FULL);
    assign b_valid = (state[1] == FULL);
    assign c_valid = (state[2] == FULL);
    assign a_data  = data_q[0];
    assign b_data  = data_q[1];
    assign c_data  = data_q[2];

`ifdef DEMUX3_ERRCNT_EN
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (illegal && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign err_cnt = cnt;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_demux3_stream.sv
// Directed self-checking bench for demux3_stream; expected err_cnt follows DEMUX3_ERRCNT_EN.
module tb_demux3_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sel;
    logic [7:0] in_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_ready, b_ready, c_ready;
    logic [7:0] a_data, b_data, c_data;
    logic       err;
    logic [7:0] err_cnt;

    int vectors    = 0;
    int miscompares = 0;

    demux3_stream #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'b00; in_data = 8'h00;
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        step(); step();
        vectors++; if ({a_valid, b_valid, c_valid} !== 3'b000) begin miscompares++; $display("FAIL reset_valids: got %b expected 000", {a_valid, b_valid, c_valid}); end
        vectors++; if ({a_data, b_data, c_data} !== 24'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 000000", {a_data, b_data, c_data}); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
        vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready sel=%0d: got %b expected 1", s, in_ready); end
        end
        step();
    endtask

    task automatic test_route();
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
        in_valid = 1'b1; in_sel = 2'b00; in_data = 8'h11;
        step();
        vectors++; if ({a_valid, b_valid, c_valid} !== 3'b100 || a_data !== 8'h11) begin miscompares++; $display("FAIL route_a: got v=%b d=%h expected v=100 d=11", {a_valid, b_valid, c_valid}, a_data); end
        in_sel = 2'b01; in_data = 8'h22;
        step();
        vectors++; if ({a_valid, b_valid, c_valid} !== 3'b010 || b_data !== 8'h22) begin miscompares++; $display("FAIL route_b: got v=%b d=%h expected v=010 d=22", {a_valid, b_valid, c_valid}, b_data); end
        in_sel = 2'b10; in_data = 8'h33;
        step();
        vectors++; if ({a_valid, b_valid, c_valid} !== 3'b001 || c_data !== 8'h33) begin miscompares++; $display("FAIL route_c: got v=%b d=%h expected v=001 d=33", {a_valid, b_valid, c_valid}, c_data); end
        in_valid = 1'b0;
        step();
        vectors++; if ({a_valid, b_valid, c_valid} !== 3'b000) begin miscompares++; $display("FAIL route_drain: got %b expected 000", {a_valid, b_valid, c_valid}); end
    endtask

    task automatic test_backpressure();
        a_ready = 1'b0; b_ready = 1'b1; c_ready = 1'b1;
        in_valid = 1'b1; in_sel = 2'b00; in_data = 8'h44;
        step();
        vectors++; if (a_valid !== 1'b1 || a_data !== 8'h44) begin miscompares++; $display("FAIL bp_load44: got v=%b d=%h expected v=1 d=44", a_valid, a_data); end
        in_data = 8'h55;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall_ready: got %b expected 0", in_ready); end
        step();
        vectors++; if (a_valid !== 1'b1 || a_data !== 8'h44) begin miscompares++; $display("FAIL bp_hold44: got v=%b d=%h expected v=1 d=44", a_valid, a_data); end
        in_sel = 2'b01; in_data = 8'h66;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_other_ready: got %b expected 1", in_ready); end
        step();
        vectors++; if (b_valid !== 1'b1 || b_data !== 8'h66 || a_data !== 8'h44) begin miscompares++; $display("FAIL bp_b66: got bv=%b bd=%h ad=%h expected bv=1 bd=66 ad=44", b_valid, b_data, a_data); end
        in_sel = 2'b00; in_data = 8'h55; a_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        step();
        vectors++; if (a_valid !== 1'b1 || a_data !== 8'h55 || b_valid !== 1'b0) begin miscompares++; $display("FAIL bp_reload55: got av=%b ad=%h bv=%b expected av=1 ad=55 bv=0", a_valid, a_data, b_valid); end
        in_valid = 1'b0;
        step();
        vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b expected 0", a_valid); end
    endtask

    task automatic test_streaming();
        c_ready = 1'b1; in_valid = 1'b1; in_sel = 2'b10;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(i);
            #1;
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready beat %0d: got %b expected 1", i, in_ready); end
            step();
            vectors++; if (c_valid !== 1'b1 || c_data !== 8'(i)) begin miscompares++; $display("FAIL stream_data beat %0d: got v=%b d=%h expected v=1 d=%h", i, c_valid, c_data, 8'(i)); end
        end
        in_valid = 1'b0;
        step();
        vectors++; if (c_valid !== 1'b0) begin miscompares++; $display("FAIL stream_end: got %b expected 0", c_valid); end
    endtask

    task automatic test_illegal();
        logic [7:0] exp_cnt;
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL illegal_err_idle: got %b expected 0", err); end
        in_valid = 1'b1; in_sel = 2'b11;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'hE0 + 8'(k);
            #1;
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_ready %0d: got %b expected 1", k, in_ready); end
            step();
            vectors++; if (err !== 1'b1 || {a_valid, b_valid, c_valid} !== 3'b000) begin miscompares++; $display("FAIL illegal_err %0d: got err=%b v=%b expected err=1 v=000", k, err, {a_valid, b_valid, c_valid}); end
        end
        in_valid = 1'b0;
        step();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL illegal_err_end: got %b expected 0", err); end
`ifdef DEMUX3_ERRCNT_EN
        exp_cnt = 8'd3;
`else
        exp_cnt = 8'd0;
`endif
        vectors++; if (err_cnt !== exp_cnt) begin miscompares++; $display("FAIL illegal_cnt3: got %0d expected %0d", err_cnt, exp_cnt); end
        in_valid = 1'b1;
        for (int k = 3; k < 260; k++) begin
            step();
            if (k == 253) begin
`ifdef DEMUX3_ERRCNT_EN
                exp_cnt = 8'd254;
`endif
                vectors++; if (err_cnt !== exp_cnt) begin miscompares++; $display("FAIL illegal_cnt254: got %0d expected %0d", err_cnt, exp_cnt); end
            end
        end
        in_valid = 1'b0;
        step();
`ifdef DEMUX3_ERRCNT_EN
        exp_cnt = 8'd255;
`endif
        vectors++; if (err_cnt !== exp_cnt) begin miscompares++; $display("FAIL illegal_cnt_sat: got %0d expected %0d", err_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        in_valid = 1'b1; in_sel = 2'b00; in_data = 8'hA1;
        step();
        in_sel = 2'b10; in_data = 8'hC1;
        step();
        vectors++; if ({a_valid, b_valid, c_valid} !== 3'b101) begin miscompares++; $display("FAIL rstmid_pre: got %b expected 101", {a_valid, b_valid, c_valid}); end
        rst = 1'b1; in_sel = 2'b01; in_data = 8'h77;
        step();
        vectors++; if ({a_valid, b_valid, c_valid} !== 3'b000) begin miscompares++; $display("FAIL rstmid_valids: got %b expected 000", {a_valid, b_valid, c_valid}); end
        vectors++; if ({a_data, b_data, c_data} !== 24'h0) begin miscompares++; $display("FAIL rstmid_data: got %h expected 000000", {a_data, b_data, c_data}); end
        vectors++; if (err_cnt !== 8'd0 || err !== 1'b0) begin miscompares++; $display("FAIL rstmid_err: got err=%b cnt=%0d expected err=0 cnt=0", err, err_cnt); end
        rst = 1'b0; in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_route();
        test_backpressure();
        test_streaming();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
